// File: rtl/branch_pkg.sv
// Shared definitions for the Mini SRC conditional-branch sequencer:
// state encoding, branch opcode, condition encoding and IR field positions.
package branch_pkg;

    localparam logic [4:0] BR_OPCODE = 5'b10010;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 27;
    localparam int COND_MSB = 20;
    localparam int COND_LSB = 19;
    localparam int C_MSB    = 18;
    localparam int C_LSB    = 0;

    // IR[20:19] condition encoding, evaluated by the CON FF logic
    typedef enum logic [1:0] {
        COND_ZERO    = 2'd0,
        COND_NONZERO = 2'd1,
        COND_POS     = 2'd2,
        COND_NEG     = 2'd3
    } cond_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T3   = 3'd1,
        S_T4   = 3'd2,
        S_T5   = 3'd3,
        S_T6   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    function automatic logic is_branch(input logic [31:0] ir);
        return ir[OPC_MSB:OPC_LSB] == BR_OPCODE;
    endfunction

endpackage

// File: rtl/branch_stats.sv
// Saturating retire counters for taken / not-taken branches.
// Only instantiated when BRANCH_STATS_EN is defined.
module branch_stats (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        retire,
    input  logic        retire_taken,
    output logic [15:0] taken_cnt,
    output logic [15:0] nottaken_cnt
);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            taken_cnt    <= 16'h0000;
            nottaken_cnt <= 16'h0000;
        end else if (retire) begin
            if (retire_taken) begin
                if (taken_cnt != 16'hFFFF)
                    taken_cnt <= taken_cnt + 16'h0001;
            end else begin
                if (nottaken_cnt != 16'hFFFF)
                    nottaken_cnt <= nottaken_cnt + 16'h0001;
            end
        end
    end

endmodule

// File: rtl/branch_sequencer.sv
// Control sequencer for Mini SRC conditional branches (T3..T6 strobes).
// Optional BRANCH_STATS_EN adds saturating taken/not-taken retire counters.
module branch_sequencer
    import branch_pkg::*;
(
    input  logic        clock,
    input  logic        clear_n,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic        busy,
    output logic        done,
    output logic        bad_op,
    output logic        gra,
    output logic        r_out,
    output logic        con_in,
    output logic        pc_out,
    output logic        y_in,
    output logic        c_out,
    output logic        alu_add,
    output logic        z_in,
    output logic        zlo_out,
    output logic        pc_in,
    output logic        taken
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0] taken_cnt,
    output logic [15:0] nottaken_cnt
`endif
);

    state_t state;
    state_t next_state;

    // Condition and offset are consumed by the datapath, not by this sequencer
    logic unused_ir;
    assign unused_ir = ^{ir[COND_MSB:COND_LSB], ir[C_MSB:C_LSB], ir[26:21]};

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start && is_branch(ir)) next_state = S_T3;
            S_T3:   next_state = S_T4;
            S_T4:   next_state = con_ff ? S_T5 : S_DONE;
            S_T5:   next_state = S_T6;
            S_T6:   next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state  <= S_IDLE;
            taken  <= 1'b0;
            bad_op <= 1'b0;
        end else begin
            state  <= next_state;
            bad_op <= (state == S_IDLE) && start && !is_branch(ir);
            if (state == S_T4)
                taken <= con_ff;
        end
    end

    // Moore strobe decode; each state owns exactly one strobe group
    always_comb begin
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        gra     = (state == S_T3);
        r_out   = (state == S_T3);
        con_in  = (state == S_T3);
        pc_out  = (state == S_T4);
        y_in    = (state == S_T4);
        c_out   = (state == S_T5);
        alu_add = (state == S_T5);
        z_in    = (state == S_T5);
        zlo_out = (state == S_T6);
        pc_in   = (state == S_T6);
    end

`ifdef BRANCH_STATS_EN
    logic retire;
    logic retire_taken;

    assign retire       = (state == S_T6) || ((state == S_T4) && !con_ff);
    assign retire_taken = (state == S_T6);

    branch_stats u_stats (
        .clock        (clock),
        .clear_n      (clear_n),
        .retire       (retire),
        .retire_taken (retire_taken),
        .taken_cnt    (taken_cnt),
        .nottaken_cnt (nottaken_cnt)
    );
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed scoreboard bench for branch_sequencer; expected per-cycle outputs
// are queued when stimulus is driven and popped at each negedge.
module tb_branch_sequencer;

    logic        clock   = 1'b0;
    logic        clear_n = 1'b1;
    logic        start   = 1'b0;
    logic [31:0] ir      = 32'h0;
    logic        con_ff  = 1'b0;

    logic busy, done, bad_op, gra, r_out, con_in, pc_out, y_in;
    logic c_out, alu_add, z_in, zlo_out, pc_in, taken;
`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt, nottaken_cnt;
`endif

    typedef struct packed {
        logic busy, done, bad_op, gra, r_out, con_in, pc_out, y_in;
        logic c_out, alu_add, z_in, zlo_out, pc_in, taken;
    } obs_t;

    obs_t observed;
    obs_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   done_seen = 0;
    int   pc_in_seen = 0;
    logic exp_taken = 1'b0;

    localparam logic [31:0] BR_IR  = {5'b10010, 6'd0, 2'd0, 19'h00010};
    localparam logic [31:0] BAD_IR = {5'b00011, 27'h0};

    branch_sequencer dut (
        .clock   (clock),
        .clear_n (clear_n),
        .start   (start),
        .ir      (ir),
        .con_ff  (con_ff),
        .busy    (busy),
        .done    (done),
        .bad_op  (bad_op),
        .gra     (gra),
        .r_out   (r_out),
        .con_in  (con_in),
        .pc_out  (pc_out),
        .y_in    (y_in),
        .c_out   (c_out),
        .alu_add (alu_add),
        .z_in    (z_in),
        .zlo_out (zlo_out),
        .pc_in   (pc_in),
        .taken   (taken)
`ifdef BRANCH_STATS_EN
        ,
        .taken_cnt    (taken_cnt),
        .nottaken_cnt (nottaken_cnt)
`endif
    );

    always #5 clock = ~clock;

    always_comb observed = {busy, done, bad_op, gra, r_out, con_in, pc_out, y_in,
                            c_out, alu_add, z_in, zlo_out, pc_in, taken};

    always @(negedge clock) begin
        if (done)  done_seen++;
        if (pc_in) pc_in_seen++;
    end

    // phase: 0 idle, 1 T3, 2 T4, 3 T5, 4 T6, 5 done, 6 bad_op pulse
    function automatic obs_t model(input int phase, input logic tk);
        obs_t o;
        o = '0;
        o.taken = tk;
        case (phase)
            1: begin o.busy = 1; o.gra = 1; o.r_out = 1; o.con_in = 1; end
            2: begin o.busy = 1; o.pc_out = 1; o.y_in = 1; end
            3: begin o.busy = 1; o.c_out = 1; o.alu_add = 1; o.z_in = 1; end
            4: begin o.busy = 1; o.zlo_out = 1; o.pc_in = 1; end
            5: begin o.busy = 1; o.done = 1; end
            6: o.bad_op = 1;
            default: ;
        endcase
        return o;
    endfunction

    task automatic push_phase(input int phase, input logic tk);
        sb.push_back(model(phase, tk));
    endtask

    task automatic push_branch(input logic tk);
        push_phase(1, exp_taken);
        push_phase(2, exp_taken);
        if (tk) begin
            push_phase(3, 1'b1);
            push_phase(4, 1'b1);
        end
        push_phase(5, tk);
        exp_taken = tk;
    endtask

    task automatic check_output(input string tag);
        obs_t exp;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s observed=%b expected=<empty scoreboard>", tag, observed);
            return;
        end
        exp = sb.pop_front();
        assert (observed === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, exp);
        end
    endtask

    task automatic check_value(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        @(negedge clock);
        check_output(tag);
    endtask

    initial begin
        int pc_base;
        int done_base;

        // reset
        #1 clear_n = 1'b0;
        #1 push_phase(0, 1'b0);
        check_output("reset");
        repeat (2) @(negedge clock);
        clear_n = 1'b1;
        push_phase(0, 1'b0);
        tick("idle_after_reset");

        // taken branch
        $display("[TB] taken branch");
        pc_base = pc_in_seen;
        ir = BR_IR; con_ff = 1'b1; start = 1'b1;
        push_branch(1'b1);
        push_phase(0, 1'b1);
        tick("tk_t3");
        start = 1'b0;
        tick("tk_t4");
        tick("tk_t5");
        tick("tk_t6");
        tick("tk_done");
        tick("tk_idle");
        check_value("tk_pc_in_cycles", pc_in_seen - pc_base, 1);

        // not-taken branch
        $display("[TB] not-taken branch");
        pc_base = pc_in_seen;
        con_ff = 1'b0; start = 1'b1;
        push_branch(1'b0);
        push_phase(0, 1'b0);
        tick("nt_t3");
        start = 1'b0;
        tick("nt_t4");
        tick("nt_done");
        tick("nt_idle");
        check_value("nt_pc_in_cycles", pc_in_seen - pc_base, 0);

        // non-branch opcode
        $display("[TB] bad opcode");
        ir = BAD_IR; start = 1'b1;
        push_phase(6, exp_taken);
        push_phase(0, exp_taken);
        tick("bad_pulse");
        start = 1'b0;
        tick("bad_idle");

        // start during T4 ignored, back-to-back start after done
        $display("[TB] start while busy");
        done_base = done_seen;
        ir = BR_IR; con_ff = 1'b1; start = 1'b1;
        push_branch(1'b1);
        tick("bz_t3");
        start = 1'b0;
        tick("bz_t4");
        start = 1'b1;
        tick("bz_t5");
        start = 1'b0;
        tick("bz_t6");
        tick("bz_done");
        start = 1'b1; con_ff = 1'b0;
        push_phase(0, exp_taken);
        tick("bz_idle");
        push_branch(1'b0);
        push_phase(0, 1'b0);
        tick("b2b_t3");
        start = 1'b0;
        tick("b2b_t4");
        tick("b2b_done");
        tick("b2b_idle");
        check_value("bz_done_count", done_seen - done_base, 2);

        // reset during T5
        $display("[TB] reset mid-sequence");
        pc_base = pc_in_seen;
        con_ff = 1'b1; start = 1'b1;
        push_phase(1, exp_taken);
        push_phase(2, exp_taken);
        push_phase(3, 1'b1);
        tick("rs_t3");
        start = 1'b0;
        tick("rs_t4");
        tick("rs_t5");
        #2 clear_n = 1'b0;
        exp_taken = 1'b0;
        #1 push_phase(0, 1'b0);
        check_output("rs_async_zero");
        @(negedge clock);
        clear_n = 1'b1;
        push_phase(0, 1'b0);
        tick("rs_idle");
        check_value("rs_pc_in_cycles", pc_in_seen - pc_base, 0);

`ifdef BRANCH_STATS_EN
        $display("[TB] branch statistics");
        for (int i = 0; i < 5; i++) begin
            logic tk;
            tk = (i < 3);
            con_ff = tk; start = 1'b1;
            push_branch(tk);
            push_phase(0, tk);
            tick("st_t3");
            start = 1'b0;
            tick("st_t4");
            if (tk) begin
                tick("st_t5");
                tick("st_t6");
            end
            tick("st_done");
            tick("st_idle");
        end
        check_value("st_taken_cnt", int'(taken_cnt), 3);
        check_value("st_nottaken_cnt", int'(nottaken_cnt), 2);

        force dut.u_stats.taken_cnt = 16'hFFFE;
        #1 release dut.u_stats.taken_cnt;
        for (int i = 0; i < 2; i++) begin
            con_ff = 1'b1; start = 1'b1;
            push_branch(1'b1);
            push_phase(0, 1'b1);
            tick("sat_t3");
            start = 1'b0;
            tick("sat_t4");
            tick("sat_t5");
            tick("sat_t6");
            tick("sat_done");
            tick("sat_idle");
        end
        check_value("sat_taken_cnt", int'(taken_cnt), 16'hFFFF);
        check_value("sat_nottaken_cnt", int'(nottaken_cnt), 2);
`endif

        check_value("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Control sequencer for the conditional-branch instruction class in the Mini SRC datapath. On a decoded branch it drives the bus strobes that load the condition register onto the bus and pulse the CON flip-flop. It then consumes the resulting CON flag and either steps the PC-plus-offset addition and PC write, or retires early. It sits directly downstream of the CON flip-flop and upstream of the PC register write enable.

## Interface
- BR_OPCODE, 5'b10010, IR[31:27] value identifying the branch class
- clock  in  1  system clock, all state on rising edge
- clear_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request from main control: IR holds a freshly decoded instruction
- ir  in  32  instruction register contents; IR[20:19] is the condition field, IR[18:0] is the offset C
- con_ff  in  1  CON flip-flop output
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on retire
- bad_op  out  1  one-cycle pulse: start seen with a non-branch opcode
- gra, r_out, con_in  out  1 each  T3 strobes: select Ra, drive it on the bus, clock the CON FF
- pc_out, y_in  out  1 each  T4 strobes
- c_out, alu_add, z_in  out  1 each  T5 strobes: sign-extended C on the bus, ALU add, latch Z
- zlo_out, pc_in  out  1 each  T6 strobes
- taken  out  1  registered branch decision, valid from end of T4 until the next start

## Operation
- States: IDLE, T3, T4, T5, T6, DONE. All outputs are Moore, decoded from registered state.
- IDLE:
  - start=1 with ir[31:27]==BR_OPCODE → T3.
  - start=1 with any other opcode → pulse bad_op, stay in IDLE.
- T3: gra=r_out=con_in=1 → T4. The con_in rising edge clocks the CON FF.
- T4: pc_out=y_in=1. At the end of T4, con_ff is captured into taken.
  - taken=1 → T5.
  - taken=0 → DONE. Not-taken branches skip the adder cycle.
- T5: c_out=alu_add=z_in=1 → T6.
- T6: zlo_out=pc_in=1 → DONE. pc_in is asserted only in T6.
- DONE: done=1 → IDLE.
- busy=1 in every state except IDLE.
- start is ignored while busy. It causes no queuing and no bad_op.
- At most one strobe group is active per cycle. Strobe groups never overlap.
- Reset values: state=IDLE and taken=0. Every strobe, busy, done and bad_op are 0.
- Reset asserted mid-sequence returns to IDLE immediately. No partial PC write may complete. pc_in must be 0 within the reset assertion cycle.

## Timing
- start is sampled at edge 0.
- Taken: T3 in cycle 1, T4 in cycle 2, T5 in cycle 3, T6 in cycle 4, done in cycle 5. Latency is 5 cycles.
- Not taken: T3 in cycle 1, T4 in cycle 2, done in cycle 3. Latency is 3 cycles.
- con_ff must be stable within one cycle of the con_in rise. It is sampled a full cycle after that rise, at the end of T4.
- A new start is accepted back-to-back in the cycle after done, when the block is in IDLE.

## Configuration
- BRANCH_STATS_EN defined:
  - Adds outputs taken_cnt[15:0] and nottaken_cnt[15:0].
  - Each counter increments once per retired branch, on entry to DONE.
  - Both counters saturate at 16'hFFFF.
  - Both reset to 0 on clear_n.
- BRANCH_STATS_EN not defined: the ports and the counters are absent. Sequencing is otherwise identical.

## Structure
- Shared package branch_pkg holds:
  - the state enum
  - BR_OPCODE default
  - the condition encoding for IR[20:19]: 0=zero, 1=nonzero, 2=positive, 3=negative
  - field slice constants for opcode, condition and C
- Sub-module branch_stats holds the two saturating counters. It is instantiated only under BRANCH_STATS_EN.

## Test plan
- Reset, then ir=BR_OPCODE with condition 0 and R=0, so con_ff=1. Pulse start → strobe groups T3,T4,T5,T6 on cycles 1–4; done on cycle 5; taken=1; pc_in high exactly one cycle.
- Same instruction with con_ff=0 → T3, T4, then done on cycle 3; c_out, z_in and pc_in never assert; taken=0.
- start with ir[31:27]=5'b00011 → bad_op pulses one cycle, busy stays 0, no strobes.
- start reasserted during T4 → ignored; exactly one done; next start after done accepted next cycle.
- clear_n low during T5 → all outputs 0 asynchronously; state IDLE after release; pc_in never asserted.
- With BRANCH_STATS_EN: 3 taken and 2 not-taken branches → taken_cnt=3, nottaken_cnt=2. Preload near 16'hFFFF and retire 2 taken → taken_cnt holds at 16'hFFFF.
